fp_div_sched: RTL and testbench
===============================

# fp_div_sched

Time-multiplexed fractional clock scheduler. One phase-accumulator adder is shared round-robin among NUM_CH channels, and each channel synthesizes its own 50:50 clock plus rise and fall strobes. A valid/ready configuration port retunes any channel's increment at runtime, either immediately or phase-coherently at the channel's next rising edge. It replaces per-channel fp_div instances wherever many slow synthesized clocks (UART baud, audio, NTSC color-burst references) are needed from one system clock.

## Interface
- NUM_CH, 4: channel count, 2..16; each channel is serviced once every NUM_CH cycles.
- ACC_W, 32: accumulator and increment width in bits.
- TO_W, 8: sync timeout counter width (used only with FP_SCHED_SYNC_TIMEOUT_EN).
- clk_in  in  1  system clock; all logic is on its rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable; sampled only in that channel's slot.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  high when no update is pending.
- cfg_ch  in  $clog2(NUM_CH)  target channel.
- cfg_inc  in  ACC_W  new increment.
- cfg_sync  in  1  1 = apply phase-coherently; 0 = apply at the next slot.
- cfg_clamp  out  1  one-cycle pulse when an accepted cfg_inc was clamped.
- cfg_timeout  out  1  one-cycle pulse when a sync apply was forced (0 without the macro).
- clk_out  out  NUM_CH  synthesized clocks, one per channel; each is the accumulator MSB.
- clk_p0  out  NUM_CH  one-cycle strobe at the rise of clk_out[ch].
- clk_p180  out  NUM_CH  one-cycle strobe at the fall of clk_out[ch].

## Operation
- **Slot counter.** Counts 0..NUM_CH-1 and wraps. Only channel `slot` is updated in a given cycle.
- **Increment register.** Each channel holds inc[ch]; its reset value is 0.
- **Enabled update.** In slot ch with ch_en[ch]=1: acc[ch] <= acc[ch] + inc_eff, modulo 2^ACC_W.
- **Disabled update.** In slot ch with ch_en[ch]=0: acc[ch] <= 0. clk_out[ch] drops with no p180 pulse, and no strobes are produced.
- **Strobes.**
  - clk_p0[ch] pulses when an update changes the MSB from 0 to 1.
  - clk_p180[ch] pulses when an update changes the MSB from 1 to 0.
  - Both strobes are zero in every other cycle.
- **Output frequency.** f_out = (f_clk / NUM_CH) * inc / 2^ACC_W.
- **Clamp.** inc must be below 2^(ACC_W-1). A larger cfg_inc is stored as 2^(ACC_W-1)-1 and cfg_clamp pulses in the acceptance cycle.
- **Config FSM, IDLE.**
  - cfg_ready=1.
  - A transfer occurs on cfg_valid & cfg_ready.
  - The transfer latches ch, inc and sync, then moves to PEND.
- **Config FSM, PEND.**
  - cfg_ready=0.
  - Apply condition is checked only when slot == pend_ch.
  - sync=0: apply in that slot. This slot's update already uses the new inc.
  - sync=1: apply in the slot whose update, made with the old inc, produces clk_p0. All later updates use the new inc.
  - sync=1 fallback: if ch_en[pend_ch]=0 or the old inc is 0 in that slot, apply immediately as for sync=0.
  - After apply, return to IDLE.
- **Slot collision.** A request accepted in the cycle where slot == cfg_ch cannot apply in that slot. Its earliest apply is NUM_CH cycles later.

## Timing
- **Reset.** While rst_in is high, or after any assertion including mid-operation:
  - slot=0, all acc=0, all inc=0, FSM=IDLE.
  - clk_out, clk_p0, clk_p180, cfg_clamp and cfg_timeout are 0; cfg_ready=1.
  - Any pending update is discarded.
- **Slot after reset.** The first clock edge after rst_in deasserts services slot 0.
- **Output latency.** clk_out, clk_p0 and clk_p180 are registered and change on the edge that updates acc[ch]: one cycle after the slot's input cycle.
- **cfg_ready.** Falls on the edge after acceptance. It rises on the edge after the apply cycle, so the minimum spacing between transfers is 2 cycles.
- **Apply latency, sync=0.** 1 to NUM_CH cycles after acceptance.

## Configuration
- **FP_SCHED_SYNC_TIMEOUT_EN defined.** PEND counts visits to pend_ch (TO_W bits). When the count reaches 2^TO_W-1 without a coherent apply, the update is forced in that slot and cfg_timeout pulses for one cycle.
- **Macro undefined.** No counter exists, cfg_timeout is tied to 0, and a sync update waits indefinitely apart from the fallback rules.

## Test plan
All scenarios use NUM_CH=4 and ACC_W=32.
- **Basic rate.** Reset, write ch0 inc=0x40000000 with sync=0, ch_en=4'b0001 -> clk_p0[0] every 16 cycles, clk_p180[0] 8 cycles after each p0, clk_out[0] 50:50.
- **Channel independence.** ch1 inc=0x20000000 while ch0 runs -> ch1 period 32 cycles, ch0 timing unchanged.
- **Clamp.** Write inc=0x90000000 -> cfg_clamp pulses once, stored inc=0x7FFFFFFF, cfg_ready low for at least 2 cycles.
- **Coherent retune.** ch0 running at 0x40000000, then sync=1 write of 0x20000000 -> apply coincides with a clk_p0[0], and the next p0 follows 32 cycles later.
- **Disable and reset.** Drop ch_en[0] mid-high -> clk_out[0] 0 at the next slot with no p180. Assert rst_in with PEND active -> all outputs 0 and cfg_ready=1 immediately.
- **Timeout and fallback.** Sync write to a channel with inc=0 -> immediate apply via fallback. With the macro defined and inc=1, a sync write forces apply after 255 visits with a cfg_timeout pulse.

Source files
------------

// File: rtl/fp_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_sched
// Purpose  : Time-multiplexed fractional clock scheduler. A single phase
//            accumulator adder is shared round-robin among NUM_CH channels;
//            each channel produces a 50:50 clock (accumulator MSB) plus
//            one-cycle rise (p0) and fall (p180) strobes. A valid/ready port
//            retunes a channel's increment either at its next slot or
//            phase-coherently at the channel's next rising edge.
// Ports    : clk_in, rst_in (async, active high)
//            ch_en[NUM_CH]            per-channel run enable
//            cfg_valid/cfg_ready      config handshake
//            cfg_ch, cfg_inc, cfg_sync  target channel, increment, mode
//            cfg_clamp, cfg_timeout   one-cycle status pulses
//            clk_out, clk_p0, clk_p180  per-channel clocks and strobes
// Options  : FP_SCHED_SYNC_TIMEOUT_EN - bounds how long a coherent update
//            may wait before it is forced (TO_W-bit visit counter).
// Revision : 1.0 - initial release
// ============================================================================
module fp_div_sched #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 32,
  parameter int TO_W   = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]          cfg_inc,
  input  logic                      cfg_sync,
  output logic                      cfg_clamp,
  output logic                      cfg_timeout,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         clk_p0,
  output logic [NUM_CH-1:0]         clk_p180
);

  localparam int                SLOT_W      = $clog2(NUM_CH);
  localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(NUM_CH - 1);
  // Largest legal increment keeps the output at or below half the slot rate.
  localparam logic [ACC_W-1:0]  C_INC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t              r_state;
  logic [SLOT_W-1:0]   r_slot;
  logic [SLOT_W-1:0]   r_pend_ch;
  logic [ACC_W-1:0]    r_pend_inc;
  logic                r_pend_sync;
  logic                r_cfg_ready;
  logic                r_cfg_clamp;

  // Per-channel state is held inside the generate loop; these arrays give the
  // shared datapath a view of it.
  logic [ACC_W-1:0]    w_acc [NUM_CH];
  logic [ACC_W-1:0]    w_inc [NUM_CH];

  logic [ACC_W-1:0]    w_acc_cur;
  logic [ACC_W-1:0]    w_inc_cur;
  logic [ACC_W-1:0]    w_sum_old;
  logic [ACC_W-1:0]    w_inc_eff;
  logic [ACC_W-1:0]    w_sum;
  logic                w_en_cur;
  logic                w_visit;
  logic                w_fallback;
  logic                w_rise_old;
  logic                w_apply_coh;
  logic                w_apply_now;
  logic                w_apply;
  logic                w_force;

`ifdef FP_SCHED_SYNC_TIMEOUT_EN
  // The visit that brings the count to 2^TO_W-1 forces the update.
  localparam logic [TO_W-1:0] C_TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_cfg_timeout;
`endif

  // --------------------------------------------------------------------------
  // Shared datapath for the channel owning the current slot
  // --------------------------------------------------------------------------
  always_comb begin
    w_acc_cur   = w_acc[r_slot];
    w_inc_cur   = w_inc[r_slot];
    w_en_cur    = ch_en[r_slot];
    w_visit     = (r_state == ST_PEND) && (r_slot == r_pend_ch);
    // A stopped or zero-rate channel never produces a rising edge, so a
    // coherent request against it would otherwise wait forever.
    w_fallback  = !w_en_cur || (w_inc_cur == '0);
    w_sum_old   = w_acc_cur + w_inc_cur;
    w_rise_old  = !w_acc_cur[ACC_W-1] && w_sum_old[ACC_W-1];
`ifdef FP_SCHED_SYNC_TIMEOUT_EN
    w_force     = r_pend_sync && !w_fallback && !w_rise_old && (r_to_cnt == C_TO_LAST);
`else
    w_force     = 1'b0;
`endif
    // Coherent apply: this update still uses the old increment (it makes the
    // rising edge); the new one takes effect from the next visit.
    w_apply_coh = w_visit && r_pend_sync && !w_fallback && w_rise_old;
    // Immediate apply: this slot's update already uses the new increment.
    w_apply_now = w_visit && (!r_pend_sync || w_fallback || w_force);
    w_apply     = w_apply_coh || w_apply_now;
    w_inc_eff   = w_apply_now ? r_pend_inc : w_inc_cur;
    w_sum       = w_acc_cur + w_inc_eff;
  end

  // --------------------------------------------------------------------------
  // Slot counter and configuration FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state       <= ST_IDLE;
      r_slot        <= '0;
      r_pend_ch     <= '0;
      r_pend_inc    <= '0;
      r_pend_sync   <= 1'b0;
      r_cfg_ready   <= 1'b1;
      r_cfg_clamp   <= 1'b0;
`ifdef FP_SCHED_SYNC_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_cfg_timeout <= 1'b0;
`endif
    end else begin
      r_slot      <= (r_slot == C_SLOT_LAST) ? '0 : r_slot + SLOT_W'(1);
      r_cfg_clamp <= 1'b0;
`ifdef FP_SCHED_SYNC_TIMEOUT_EN
      r_cfg_timeout <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (cfg_valid && r_cfg_ready) begin
            r_pend_ch   <= cfg_ch;
            r_pend_sync <= cfg_sync;
            if (cfg_inc[ACC_W-1]) begin
              r_pend_inc  <= C_INC_MAX;
              r_cfg_clamp <= 1'b1;
            end else begin
              r_pend_inc  <= cfg_inc;
            end
            r_state     <= ST_PEND;
            r_cfg_ready <= 1'b0;
`ifdef FP_SCHED_SYNC_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
          end
        end
        ST_PEND: begin
          if (w_apply) begin
            r_state     <= ST_IDLE;
            r_cfg_ready <= 1'b1;
`ifdef FP_SCHED_SYNC_TIMEOUT_EN
            r_cfg_timeout <= w_force;
`endif
          end
`ifdef FP_SCHED_SYNC_TIMEOUT_EN
          else if (w_visit) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
`endif
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel accumulator, increment and strobe registers
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [SLOT_W-1:0] C_ID = SLOT_W'(g);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic             r_p0;
    logic             r_p180;

    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        r_acc  <= '0;
        r_inc  <= '0;
        r_p0   <= 1'b0;
        r_p180 <= 1'b0;
      end else begin
        r_p0   <= 1'b0;
        r_p180 <= 1'b0;
        if (r_slot == C_ID) begin
          if (ch_en[g]) begin
            r_acc  <= w_sum;
            r_p0   <= !r_acc[ACC_W-1] &&  w_sum[ACC_W-1];
            r_p180 <=  r_acc[ACC_W-1] && !w_sum[ACC_W-1];
          end else begin
            // Stopping forces the clock low silently: no fall strobe.
            r_acc  <= '0;
          end
          if (w_apply) begin
            r_inc <= r_pend_inc;
          end
        end
      end
    end

    assign w_acc[g]    = r_acc;
    assign w_inc[g]    = r_inc;
    assign clk_out[g]  = r_acc[ACC_W-1];
    assign clk_p0[g]   = r_p0;
    assign clk_p180[g] = r_p180;
  end

  assign cfg_ready = r_cfg_ready;
  assign cfg_clamp = r_cfg_clamp;
`ifdef FP_SCHED_SYNC_TIMEOUT_EN
  assign cfg_timeout = r_cfg_timeout;
`else
  assign cfg_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div_sched
// Purpose  : Directed self-checking bench for fp_div_sched (NUM_CH=4,
//            ACC_W=32). Strobe timing is collected on falling clock edges and
//            compared against hand-derived periods, offsets and latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_div_sched;

  localparam int NUM_CH = 4;
  localparam int ACC_W  = 32;
  localparam int TO_W   = 8;

  logic                clk_in = 1'b0;
  logic                rst_in = 1'b1;
  logic [NUM_CH-1:0]   ch_en = '0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [1:0]          cfg_ch = '0;
  logic [ACC_W-1:0]    cfg_inc = '0;
  logic                cfg_sync = 1'b0;
  logic                cfg_clamp;
  logic                cfg_timeout;
  logic [NUM_CH-1:0]   clk_out;
  logic [NUM_CH-1:0]   clk_p0;
  logic [NUM_CH-1:0]   clk_p180;

  fp_div_sched #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .TO_W(TO_W)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .ch_en       (ch_en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_inc     (cfg_inc),
    .cfg_sync    (cfg_sync),
    .cfg_clamp   (cfg_clamp),
    .cfg_timeout (cfg_timeout),
    .clk_out     (clk_out),
    .clk_p0      (clk_p0),
    .clk_p180    (clk_p180)
  );

  always #5 clk_in = ~clk_in;

  // Edges since reset release; the slot serviced by the next edge is edge_n % 4.
  int edge_n;
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_p0 [NUM_CH];
  int p0_cnt  [NUM_CH];
  int p180_cnt[NUM_CH];
  int hi_cnt  [NUM_CH];
  int ivl_min [NUM_CH];
  int ivl_max [NUM_CH];
  int dl_min  [NUM_CH];
  int dl_max  [NUM_CH];
  int clamp_cnt = 0;
  int to_cnt    = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < NUM_CH; c++) begin
      last_p0[c]  = -1;
      p0_cnt[c]   = 0;
      p180_cnt[c] = 0;
      hi_cnt[c]   = 0;
      ivl_min[c]  = 1000000;
      ivl_max[c]  = -1;
      dl_min[c]   = 1000000;
      dl_max[c]   = -1;
    end
  endtask

  // One cycle: advance to the falling edge and fold outputs into the stats.
  task automatic tick();
    @(negedge clk_in);
    cyc++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (clk_p0[c]) begin
        if (last_p0[c] >= 0) begin
          if (cyc - last_p0[c] < ivl_min[c]) ivl_min[c] = cyc - last_p0[c];
          if (cyc - last_p0[c] > ivl_max[c]) ivl_max[c] = cyc - last_p0[c];
        end
        last_p0[c] = cyc;
        p0_cnt[c]++;
      end
      if (clk_p180[c]) begin
        p180_cnt[c]++;
        if (last_p0[c] >= 0) begin
          if (cyc - last_p0[c] < dl_min[c]) dl_min[c] = cyc - last_p0[c];
          if (cyc - last_p0[c] > dl_max[c]) dl_max[c] = cyc - last_p0[c];
        end
      end
      if (clk_out[c]) hi_cnt[c]++;
    end
    if (cfg_clamp)   clamp_cnt++;
    if (cfg_timeout) to_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a request so that it is accepted on an edge servicing `slot`.
  // rdy_after is cfg_ready sampled right after the accepting edge.
  task automatic cfg_send(input int ch, input logic [31:0] inc, input logic sync,
                          input int slot, output logic rdy_after);
    int guard;
    guard = 0;
    while (!cfg_ready && guard < 2000) begin guard++; tick(); end
    if (!cfg_ready) check_eq("send_ready_bound", 0, 1);
    guard = 0;
    while ((edge_n % NUM_CH) != slot && guard < 8) begin guard++; tick(); end
    cfg_ch    = 2'(ch);
    cfg_inc   = inc;
    cfg_sync  = sync;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    rdy_after = cfg_ready;
  endtask

  // Count falling edges with cfg_ready low until it returns high.
  task automatic cfg_wait(output int n);
    n = 0;
    while (!cfg_ready && n < 2000) begin n++; tick(); end
    if (!cfg_ready) check_eq("wait_ready_bound", 0, 1);
  endtask

  initial begin : main
    logic rdy;
    int   n, c0, t0, t180, guard, p180_0, p0_sum;

    clear_stats();
    // Reset held with a clamping request presented: nothing may respond.
    cfg_valid = 1'b1;
    cfg_inc   = 32'h9000_0000;
    ticks(3);
    check_eq("rst_clk_out",   clk_out,     0);
    check_eq("rst_p0",        clk_p0,      0);
    check_eq("rst_p180",      clk_p180,    0);
    check_eq("rst_ready",     cfg_ready,   1);
    check_eq("rst_clamp",     cfg_clamp,   0);
    check_eq("rst_timeout",   cfg_timeout, 0);
    cfg_valid = 1'b0;
    rst_in    = 1'b0;

    // Basic rate: ch0 inc=1/4 turn -> 4 updates (16 cycles) per period.
    ch_en = 4'b0001;
    c0 = clamp_cnt;
    cfg_send(0, 32'h4000_0000, 1'b0, 3, rdy);
    check_eq("basic_ready_fall", rdy, 0);
    cfg_wait(n);
    check_eq("basic_apply_lat", n, 1);
    check_eq("basic_no_clamp", clamp_cnt - c0, 0);
    clear_stats();
    ticks(160);
    check_eq("basic_p0_cnt",  p0_cnt[0],  10);
    check_eq("basic_ivl_min", ivl_min[0], 16);
    check_eq("basic_ivl_max", ivl_max[0], 16);
    check_eq("basic_dl_min",  dl_min[0],  8);
    check_eq("basic_dl_max",  dl_max[0],  8);
    check_eq("basic_duty",    hi_cnt[0],  80);

    // Channel independence: ch1 at 1/8 turn -> 32-cycle period.
    ch_en = 4'b0011;
    cfg_send(1, 32'h2000_0000, 1'b0, 0, rdy);
    cfg_wait(n);
    check_eq("indep_apply_lat", n, 1);
    clear_stats();
    ticks(320);
    check_eq("indep_ch0_cnt", p0_cnt[0],  20);
    check_eq("indep_ch0_ivl", ivl_max[0], 16);
    check_eq("indep_ch1_cnt", p0_cnt[1],  10);
    check_eq("indep_ch1_min", ivl_min[1], 32);
    check_eq("indep_ch1_max", ivl_max[1], 32);
    check_eq("indep_ch1_dl",  dl_max[1],  16);
    check_eq("indep_ch1_duty", hi_cnt[1], 160);

    // Clamp, accepted in ch2's own slot so the apply waits a full rotation.
    c0 = clamp_cnt;
    cfg_send(2, 32'h9000_0000, 1'b0, 2, rdy);
    check_eq("clamp_pulse_now", cfg_clamp, 1);
    check_eq("clamp_ready_fall", rdy, 0);
    cfg_wait(n);
    check_eq("clamp_collision_lat", n, 4);
    check_eq("clamp_pulse_cnt", clamp_cnt - c0, 1);
    // 0x7FFFFFFF toggles the MSB on every update (8-cycle period);
    // an unclamped 0x90000000 would miss edges within a few periods.
    ch_en = 4'b0111;
    ticks(8);
    clear_stats();
    ticks(200);
    check_eq("clamp_ivl_min", ivl_min[2], 8);
    check_eq("clamp_ivl_max", ivl_max[2], 8);
    check_eq("clamp_dl_max",  dl_max[2],  4);
    check_eq("clamp_ch0_ivl", ivl_min[0], 16);

    // Coherent retune of ch0 from 1/4 to 1/8 turn.
    ch_en = 4'b0001;
    cfg_send(0, 32'h2000_0000, 1'b1, 1, rdy);
    cfg_wait(n);
    check_eq("coh_apply_on_p0", clk_p0[0], 1);
    t0 = cyc; t180 = -1; guard = 0;
    do begin
      tick(); guard++;
      if (clk_p180[0]) t180 = cyc - t0;
    end while (!clk_p0[0] && guard < 100);
    check_eq("coh_next_p0", cyc - t0, 32);
    check_eq("coh_p180_ofs", t180, 16);

    // Disable mid-high: clock drops at the next slot without a p180.
    guard = 0;
    while (!clk_out[0] && guard < 64) begin guard++; tick(); end
    check_eq("dis_saw_high", clk_out[0], 1);
    ticks(2);
    ch_en[0] = 1'b0;
    p180_0 = p180_cnt[0];
    ticks(4);
    check_eq("dis_clk_low", clk_out[0], 0);
    check_eq("dis_no_p180", p180_cnt[0] - p180_0, 0);

    // Fallbacks: sync request to a zero-rate channel and to a stopped one.
    ch_en = 4'b1000;
    cfg_send(3, 32'h4000_0000, 1'b1, 2, rdy);
    cfg_wait(n);
    check_eq("fb_inc0_lat", n, 1);
    clear_stats();
    ticks(100);
    check_eq("fb_inc0_ivl_min", ivl_min[3], 16);
    check_eq("fb_inc0_ivl_max", ivl_max[3], 16);
    cfg_send(0, 32'h4000_0000, 1'b1, 3, rdy);
    cfg_wait(n);
    check_eq("fb_dis_lat", n, 1);

`ifdef FP_SCHED_SYNC_TIMEOUT_EN
    // inc=1 never reaches the MSB: forced apply on the 255th visit.
    ch_en = 4'b1001;
    cfg_send(0, 32'h0000_0001, 1'b0, 3, rdy);
    cfg_wait(n);
    c0 = to_cnt;
    cfg_send(0, 32'h4000_0000, 1'b1, 3, rdy);
    cfg_wait(n);
    check_eq("to_lat", n, 1017);
    check_eq("to_pulse_now", cfg_timeout, 1);
    check_eq("to_pulse_cnt", to_cnt - c0, 1);
`else
    check_eq("to_never", to_cnt, 0);
`endif

    // Asynchronous reset with a coherent update pending.
    ch_en = 4'b1010;
    cfg_send(1, 32'h1000_0000, 1'b1, 1, rdy);
    tick();
    check_eq("rpend_pending", cfg_ready, 0);
    #1 rst_in = 1'b1;
    #1;
    check_eq("rpend_ready",   cfg_ready,   1);
    check_eq("rpend_clk_out", clk_out,     0);
    check_eq("rpend_p0",      clk_p0,      0);
    check_eq("rpend_p180",    clk_p180,    0);
    check_eq("rpend_clamp",   cfg_clamp,   0);
    check_eq("rpend_timeout", cfg_timeout, 0);
    ticks(2);
    rst_in = 1'b0;
    ch_en  = 4'b1111;
    clear_stats();
    ticks(60);
    p0_sum = p0_cnt[0] + p0_cnt[1] + p0_cnt[2] + p0_cnt[3];
    check_eq("rpend_inc_cleared", p0_sum, 0);
    check_eq("rpend_clk_idle", clk_out, 0);
    check_eq("rpend_ready_idle", cfg_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
